// File: rtl/inference_sequencer_if.sv
// Bundle of sample, accelerator and scoring signals around the inference sequencer.
// The master side is the sample source / bench; the slave side is the sequencer.
interface inference_sequencer_if #(
    parameter int unsigned INPUT_BITS   = 784,
    parameter int unsigned BUS_WIDTH    = 64,
    parameter int unsigned CLS_WIDTH    = 4,
    parameter int unsigned CNT_WIDTH    = 16
);
    // Sample handshake
    logic                  smp_vld;
    logic                  smp_rdy;
    logic [INPUT_BITS-1:0] smp_data;
    logic [CLS_WIDTH-1:0]  smp_label;

    // Accelerator side
    logic                  dev_inp_vld;
    logic [BUS_WIDTH-1:0]  dev_inp;
    logic                  dev_stall;
    logic                  dev_outp_vld;
    logic [CLS_WIDTH-1:0]  dev_outp;

    // Scoring
    logic                  clr;
    logic                  res_vld;
    logic [CLS_WIDTH-1:0]  res_class;
    logic                  res_correct;
    logic [CNT_WIDTH-1:0]  total_cnt;
    logic [CNT_WIDTH-1:0]  correct_cnt;
    logic                  busy;
    logic                  err;

    modport master (
        output smp_vld, smp_data, smp_label, dev_stall, dev_outp_vld, dev_outp, clr,
        input  smp_rdy, dev_inp_vld, dev_inp, res_vld, res_class, res_correct,
               total_cnt, correct_cnt, busy, err
    );

    modport slave (
        input  smp_vld, smp_data, smp_label, dev_stall, dev_outp_vld, dev_outp, clr,
        output smp_rdy, dev_inp_vld, dev_inp, res_vld, res_class, res_correct,
               total_cnt, correct_cnt, busy, err
    );
endinterface

// File: rtl/inference_sequencer.sv
// Streams whole binarized samples to the accelerator in bus-width chunks, keeps the labels
// of in-flight inferences in a small FIFO and scores returned classes against them.
module inference_sequencer #(
    parameter int unsigned INPUT_BITS   = 784,
    parameter int unsigned BUS_WIDTH    = 64,
    parameter int unsigned MAX_INFLIGHT = 4,   // power of 2, at least 2
    parameter int unsigned CLS_WIDTH    = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,          // asynchronous, active low
    inference_sequencer_if.slave bus
);
    localparam int unsigned NChunks = (INPUT_BITS + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int unsigned PadBits = NChunks * BUS_WIDTH;
    localparam int unsigned IdxW    = (NChunks > 1) ? $clog2(NChunks) : 1;
    localparam int unsigned PtrW    = $clog2(MAX_INFLIGHT);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunks - 1);
    localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(MAX_INFLIGHT);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    // Holds the not-yet-sent chunks; the current chunk always sits in the low BUS_WIDTH bits.
    logic [PadBits-1:0]    sample_q, sample_d;

    logic [CLS_WIDTH-1:0]  fifo_q [MAX_INFLIGHT];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]         cnt_q, cnt_d;

    logic                  res_vld_q, res_vld_d;
    logic [CLS_WIDTH-1:0]  res_class_q, res_class_d;
    logic                  res_correct_q, res_correct_d;
    logic [CNT_WIDTH-1:0]  total_q, total_d;
    logic [CNT_WIDTH-1:0]  correct_q, correct_d;
    logic                  err_q, err_d;

    logic                  fifo_full, fifo_empty;
    logic                  last_consume;
    logic                  smp_rdy;
    logic                  accept;
    logic                  pop;
    logic                  match;
    logic [CLS_WIDTH-1:0]  head;
    logic                  dev_inp_vld;
    logic [BUS_WIDTH-1:0]  dev_inp;
    logic                  busy;

    assign fifo_full    = (cnt_q == FullCnt);
    assign fifo_empty   = (cnt_q == '0);
    assign last_consume = (state_q == StStream) && !bus.dev_stall && (idx_q == LastIdx);
    assign accept       = bus.smp_vld && smp_rdy;
    assign pop          = bus.dev_outp_vld && !fifo_empty;
    assign head         = fifo_q[rd_ptr_q];
    assign match        = (head == bus.dev_outp);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
        end
    end

    // FSM next state: load on accept, shift one chunk per unstalled cycle
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StStream;
                    idx_d    = '0;
                    sample_d = PadBits'(bus.smp_data);
                end
            end
            StStream: begin
                if (!bus.dev_stall) begin
                    if (idx_q == LastIdx) begin
                        if (accept) begin
                            // Back-to-back sample: no bubble between streams
                            idx_d    = '0;
                            sample_d = PadBits'(bus.smp_data);
                        end else begin
                            state_d  = StIdle;
                            idx_d    = '0;
                            sample_d = '0;
                        end
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        sample_d = sample_q >> BUS_WIDTH;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; smp_rdy uses pre-pop occupancy so a full FIFO never pushes and pops together
    always_comb begin
        dev_inp_vld = (state_q == StStream);
        dev_inp     = sample_q[BUS_WIDTH-1:0];
        smp_rdy     = rst && !fifo_full && ((state_q == StIdle) || last_consume);
        busy        = (state_q == StStream) || !fifo_empty;
    end

    // Label FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Label FIFO storage and pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                fifo_q[wr_ptr_q] <= bus.smp_label;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Scoring: result pulse, running counters and sticky underflow flag; clr wins over updates
    always_comb begin
        res_vld_d     = pop;
        res_class_d   = res_class_q;
        res_correct_d = res_correct_q;
        total_d       = total_q;
        correct_d     = correct_q;
        err_d         = err_q;
        if (pop) begin
            res_class_d   = bus.dev_outp;
            res_correct_d = match;
            total_d       = total_q + 1'b1;
            if (match) begin
                correct_d = correct_q + 1'b1;
            end
        end
        if (bus.dev_outp_vld && fifo_empty) begin
            err_d = 1'b1;
        end
        if (bus.clr) begin
            total_d   = '0;
            correct_d = '0;
            err_d     = 1'b0;
        end
    end

    // Scoring registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_vld_q     <= 1'b0;
            res_class_q   <= '0;
            res_correct_q <= 1'b0;
            total_q       <= '0;
            correct_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            res_vld_q     <= res_vld_d;
            res_class_q   <= res_class_d;
            res_correct_q <= res_correct_d;
            total_q       <= total_d;
            correct_q     <= correct_d;
            err_q         <= err_d;
        end
    end

    assign bus.smp_rdy     = smp_rdy;
    assign bus.dev_inp_vld = dev_inp_vld;
    assign bus.dev_inp     = dev_inp;
    assign bus.busy        = busy;
    assign bus.res_vld     = res_vld_q;
    assign bus.res_class   = res_class_q;
    assign bus.res_correct = res_correct_q;
    assign bus.total_cnt   = total_q;
    assign bus.correct_cnt = correct_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: streaming, stall, back-to-back, FIFO full,
// scoring, clear, underflow error and mid-stream reset.
module tb_inference_sequencer;
    localparam int unsigned INPUT_BITS   = 784;
    localparam int unsigned BUS_WIDTH    = 64;
    localparam int unsigned MAX_INFLIGHT = 4;
    localparam int unsigned CLS_WIDTH    = 4;
    localparam int unsigned CNT_WIDTH    = 16;
    localparam int unsigned NCHUNKS      = 13;

    logic clk = 1'b0;
    logic rst;

    inference_sequencer_if #(
        .INPUT_BITS (INPUT_BITS),
        .BUS_WIDTH  (BUS_WIDTH),
        .CLS_WIDTH  (CLS_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) bus ();

    inference_sequencer #(
        .INPUT_BITS   (INPUT_BITS),
        .BUS_WIDTH    (BUS_WIDTH),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CLS_WIDTH    (CLS_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference sample: incrementing bytes, zero padded to a whole number of chunks
    logic [NCHUNKS*BUS_WIDTH-1:0] pad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] chunk(input int c);
        return pad[c*BUS_WIDTH +: BUS_WIDTH];
    endfunction

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Return one class; checks the result pulse and counters in the following cycle
    task automatic return_result(input logic [3:0] cls, input logic exp_ok,
                                 input int exp_total, input int exp_good);
        bus.dev_outp_vld = 1'b1;
        bus.dev_outp     = cls;
        next_cycle();
        bus.dev_outp_vld = 1'b0;
        @(negedge clk);
        check("res_vld", 64'(bus.res_vld), 64'd1);
        check("res_class", 64'(bus.res_class), 64'(cls));
        check("res_correct", 64'(bus.res_correct), 64'(exp_ok));
        check("total_cnt", 64'(bus.total_cnt), 64'(exp_total));
        check("correct_cnt", 64'(bus.correct_cnt), 64'(exp_good));
        next_cycle();
    endtask

    initial begin
        rst              = 1'b0;
        bus.smp_vld      = 1'b0;
        bus.smp_label    = '0;
        bus.dev_stall    = 1'b0;
        bus.dev_outp_vld = 1'b0;
        bus.dev_outp     = '0;
        bus.clr          = 1'b0;
        pad              = '0;
        for (int b = 0; b < 98; b++) begin
            pad[8*b +: 8] = 8'(b);
        end
        bus.smp_data = pad[INPUT_BITS-1:0];

        // Reset state
        @(negedge clk);
        check("rst_smp_rdy", 64'(bus.smp_rdy), 64'd0);
        check("rst_inp_vld", 64'(bus.dev_inp_vld), 64'd0);
        check("rst_inp", bus.dev_inp, 64'd0);
        check("rst_res_vld", 64'(bus.res_vld), 64'd0);
        check("rst_total", 64'(bus.total_cnt), 64'd0);
        check("rst_correct", 64'(bus.correct_cnt), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        rst = 1'b1;
        next_cycle();

        // Single sample, label 7, no stall
        bus.smp_vld   = 1'b1;
        bus.smp_label = 4'd7;
        @(negedge clk);
        check("idle_rdy", 64'(bus.smp_rdy), 64'd1);
        next_cycle();
        bus.smp_vld = 1'b0;
        for (int c = 0; c < int'(NCHUNKS); c++) begin
            @(negedge clk);
            check("single_vld", 64'(bus.dev_inp_vld), 64'd1);
            check("single_chunk", bus.dev_inp, chunk(c));
            check("single_rdy", 64'(bus.smp_rdy), 64'(c == 12));
            if (c == 0) check("chunk0_value", bus.dev_inp, 64'h0706050403020100);
            if (c == 12) check("chunk12_value", bus.dev_inp, 64'h0000000000006160);
            next_cycle();
        end
        @(negedge clk);
        check("single_vld_drop", 64'(bus.dev_inp_vld), 64'd0);
        check("single_busy", 64'(bus.busy), 64'd1);
        next_cycle();

        // Stall for 3 cycles on chunk 5, label 3
        bus.smp_vld   = 1'b1;
        bus.smp_label = 4'd3;
        next_cycle();
        bus.smp_vld = 1'b0;
        for (int k = 0; k < 16; k++) begin
            int e;
            bus.dev_stall = (k >= 5 && k <= 7);
            e = (k < 5) ? k : ((k <= 8) ? 5 : k - 3);
            @(negedge clk);
            check("stall_vld", 64'(bus.dev_inp_vld), 64'd1);
            check("stall_chunk", bus.dev_inp, chunk(e));
            next_cycle();
        end
        bus.dev_stall = 1'b0;
        @(negedge clk);
        check("stall_vld_drop", 64'(bus.dev_inp_vld), 64'd0);
        next_cycle();

        // Score the two in-flight labels (7, 3)
        return_result(4'd7, 1'b1, 1, 1);
        return_result(4'd3, 1'b1, 2, 2);

        // Back-to-back: labels 3, 5, 9
        bus.smp_vld   = 1'b1;
        bus.smp_label = 4'd3;
        next_cycle();
        for (int k = 0; k < 39; k++) begin
            if (k == 0) bus.smp_label = 4'd5;
            if (k == 13) bus.smp_label = 4'd9;
            if (k == 26) bus.smp_vld = 1'b0;
            @(negedge clk);
            check("b2b_vld", 64'(bus.dev_inp_vld), 64'd1);
            check("b2b_chunk", bus.dev_inp, chunk(k % 13));
            check("b2b_rdy", 64'(bus.smp_rdy), 64'((k % 13) == 12));
            next_cycle();
        end
        @(negedge clk);
        check("b2b_vld_drop", 64'(bus.dev_inp_vld), 64'd0);
        next_cycle();

        // Third scored result is wrong (label 3, class 1)
        return_result(4'd1, 1'b0, 3, 2);
        bus.clr = 1'b1;
        next_cycle();
        bus.clr = 1'b0;
        @(negedge clk);
        check("clr_total", 64'(bus.total_cnt), 64'd0);
        check("clr_correct", 64'(bus.correct_cnt), 64'd0);
        next_cycle();

        // Drain labels 5 and 9; clear coincides with the second result
        return_result(4'd5, 1'b1, 1, 1);
        bus.dev_outp_vld = 1'b1;
        bus.dev_outp     = 4'd9;
        bus.clr          = 1'b1;
        next_cycle();
        bus.dev_outp_vld = 1'b0;
        bus.clr          = 1'b0;
        @(negedge clk);
        check("clr_pri_res_vld", 64'(bus.res_vld), 64'd1);
        check("clr_pri_correct_bit", 64'(bus.res_correct), 64'd1);
        check("clr_pri_total", 64'(bus.total_cnt), 64'd0);
        check("clr_pri_correct", 64'(bus.correct_cnt), 64'd0);
        check("drained_busy", 64'(bus.busy), 64'd0);
        next_cycle();

        // Result with empty FIFO
        bus.dev_outp_vld = 1'b1;
        bus.dev_outp     = 4'd2;
        next_cycle();
        bus.dev_outp_vld = 1'b0;
        @(negedge clk);
        check("underflow_err", 64'(bus.err), 64'd1);
        check("underflow_res_vld", 64'(bus.res_vld), 64'd0);
        check("underflow_total", 64'(bus.total_cnt), 64'd0);
        next_cycle();
        bus.clr = 1'b1;
        next_cycle();
        bus.clr = 1'b0;
        @(negedge clk);
        check("clr_err", 64'(bus.err), 64'd0);
        next_cycle();

        // FIFO full: five samples offered (labels 1, 2, 4, 6, 8), no results
        bus.smp_vld   = 1'b1;
        bus.smp_label = 4'd1;
        next_cycle();
        for (int k = 0; k < 52; k++) begin
            if (k == 0) bus.smp_label = 4'd2;
            if (k == 13) bus.smp_label = 4'd4;
            if (k == 26) bus.smp_label = 4'd6;
            if (k == 39) bus.smp_label = 4'd8;
            @(negedge clk);
            check("full_vld", 64'(bus.dev_inp_vld), 64'd1);
            check("full_rdy", 64'(bus.smp_rdy), 64'(((k % 13) == 12) && (k != 51)));
            next_cycle();
        end
        @(negedge clk);
        check("full_blocked0", 64'(bus.smp_rdy), 64'd0);
        check("full_idle_vld", 64'(bus.dev_inp_vld), 64'd0);
        next_cycle();
        @(negedge clk);
        check("full_blocked1", 64'(bus.smp_rdy), 64'd0);
        next_cycle();
        bus.dev_outp_vld = 1'b1;
        bus.dev_outp     = 4'd1;
        @(negedge clk);
        check("full_pop_cycle_rdy", 64'(bus.smp_rdy), 64'd0);
        next_cycle();
        bus.dev_outp_vld = 1'b0;
        @(negedge clk);
        check("full_freed_rdy", 64'(bus.smp_rdy), 64'd1);
        check("full_res_correct", 64'(bus.res_correct), 64'd1);
        check("full_total", 64'(bus.total_cnt), 64'd1);
        next_cycle();
        bus.smp_vld = 1'b0;

        // Fifth sample streams; reset lands during chunk 6
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("fifth_chunk", bus.dev_inp, chunk(k));
            if (k < 6) next_cycle();
        end
        rst = 1'b0;
        #1;
        check("mid_rst_vld", 64'(bus.dev_inp_vld), 64'd0);
        check("mid_rst_inp", bus.dev_inp, 64'd0);
        check("mid_rst_rdy", 64'(bus.smp_rdy), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_total", 64'(bus.total_cnt), 64'd0);
        check("mid_rst_correct", 64'(bus.correct_cnt), 64'd0);
        #2;
        rst = 1'b1;
        next_cycle();

        // Fresh sample after reset, label 11
        bus.smp_vld   = 1'b1;
        bus.smp_label = 4'd11;
        @(negedge clk);
        check("post_rst_rdy", 64'(bus.smp_rdy), 64'd1);
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        next_cycle();
        bus.smp_vld = 1'b0;
        for (int c = 0; c < int'(NCHUNKS); c++) begin
            @(negedge clk);
            check("post_rst_vld", 64'(bus.dev_inp_vld), 64'd1);
            check("post_rst_chunk", bus.dev_inp, chunk(c));
            next_cycle();
        end
        // Head must be the new label if the FIFO was flushed
        return_result(4'd11, 1'b1, 1, 1);
        @(negedge clk);
        check("final_busy", 64'(bus.busy), 64'd0);
        check("final_res_vld", 64'(bus.res_vld), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
